// File: rtl/video_palframe_gen_if.sv
// -----------------------------------------------------------------------------
// video_palframe_gen_if
//
// CPU-side palette bus for video_palframe_gen: a write port that is accepted
// every clock, and a level-request / pulse-acknowledge readback port.
//
// Readback handshake (one description for every user of this bus):
//   The master raises pal_rd_req and holds it with pal_rd_addr stable until it
//   sees pal_rd_ack. pal_rd_addr is captured on the first clock in which the
//   slave sees pal_rd_req high while idle. pal_rd_ack is a single-cycle pulse
//   and pal_rd_data is valid in that cycle; pal_rd_data then holds until the
//   next ack. After an ack the master must drop pal_rd_req for at least one
//   clock before the next request; a held request is never acknowledged twice.
//   Dropping pal_rd_req before the ack abandons the request with no ack.
//
// Signals:
//   pal_we       master->slave  write strobe, one entry per clock
//   pal_waddr    master->slave  write address {bank,index}
//   pal_wdata    master->slave  write data
//   pal_rd_req   master->slave  readback request (level)
//   pal_rd_addr  master->slave  readback address {bank,index}
//   pal_rd_ack   slave->master  one-cycle readback acknowledge
//   pal_rd_data  slave->master  readback data
// -----------------------------------------------------------------------------
interface video_palframe_gen_if #(
  parameter int IDX_W  = 4,
  parameter int COL_W  = 6,
  parameter int BANK_W = 1
);

  localparam int ADDR_W = BANK_W + IDX_W;

  logic              pal_we;
  logic [ADDR_W-1:0] pal_waddr;
  logic [COL_W-1:0]  pal_wdata;
  logic              pal_rd_req;
  logic [ADDR_W-1:0] pal_rd_addr;
  logic              pal_rd_ack;
  logic [COL_W-1:0]  pal_rd_data;

  modport master (
    output pal_we,
    output pal_waddr,
    output pal_wdata,
    output pal_rd_req,
    output pal_rd_addr,
    input  pal_rd_ack,
    input  pal_rd_data
  );

  modport slave (
    input  pal_we,
    input  pal_waddr,
    input  pal_wdata,
    input  pal_rd_req,
    input  pal_rd_addr,
    output pal_rd_ack,
    output pal_rd_data
  );

endinterface

// File: rtl/video_palframe_gen.sv
// -----------------------------------------------------------------------------
// video_palframe_gen
//
// Per-clock palette mixer between the pixel/border generators and the DAC.
// Each clock it picks the pixel index inside the pixel window (hpix & vpix) or
// the border index outside it. It prefixes the currently displayed bank and
// looks the result up in a multi-bank palette RAM. The output is forced to 0
// while blanked. Latency from inputs to color/blank_out is exactly 2 clocks.
//
// The displayed bank follows bank_sel only on clocks where vblank is high, so
// a bank change never tears a visible frame. The CPU can write the palette
// every clock and can read it back through a request/ack port. A readback is
// only serviced while the display pipeline is blanked, so it never steals the
// RAM read port from the display.
//
// Ports:
//   clk           video clock
//   rst_n         asynchronous active-low reset
//   hpix, vpix    horizontal / vertical pixel window
//   hblank,vblank horizontal / vertical blank
//   pixels        pixel colour index
//   border        border colour index
//   bank_sel      requested display bank
//   pal_bus       palette write + readback bus (slave side)
//   color         final colour, 0 while blanked
//   blank_out     blank flag aligned with color
//   dbg_rd_state  readback FSM state (0 IDLE, 1 WAIT, 2 READ, 3 ACK)
// -----------------------------------------------------------------------------
module video_palframe_gen #(
  parameter int IDX_W  = 4,
  parameter int COL_W  = 6,
  parameter int BANK_W = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                hpix,
  input  logic                vpix,
  input  logic                hblank,
  input  logic                vblank,
  input  logic [IDX_W-1:0]    pixels,
  input  logic [IDX_W-1:0]    border,
  input  logic [BANK_W-1:0]   bank_sel,
  video_palframe_gen_if.slave pal_bus,
  output logic [COL_W-1:0]    color,
  output logic                blank_out,
  output logic [1:0]          dbg_rd_state
);

  localparam int ADDR_W = BANK_W + IDX_W;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_READ = 2'd2,
    S_ACK  = 2'd3
  } rd_state_e;

  // ---------------------------------------------------------------------------
  // Palette storage. Not reset: contents are undefined until written.
  // All reads use non-blocking semantics, so a read at the same edge as a
  // write to that address returns the old entry.
  // ---------------------------------------------------------------------------
  logic [COL_W-1:0] pal_q [DEPTH];

  always_ff @(posedge clk) begin
    if (pal_bus.pal_we) begin
      pal_q[pal_bus.pal_waddr] <= pal_bus.pal_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Display bank: only follows bank_sel during vertical blank.
  // ---------------------------------------------------------------------------
  logic [BANK_W-1:0] bank_cur_q, bank_cur_d;

  always_comb begin
    bank_cur_d = bank_cur_q;
    if (vblank) begin
      bank_cur_d = bank_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_cur_q <= '0;
    end else begin
      bank_cur_q <= bank_cur_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: index select, blank combine, full RAM address.
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] addr1_q, addr1_d;
  logic              blk1_q,  blk1_d;
  logic [IDX_W-1:0]  idx1;

  always_comb begin
    idx1    = (hpix && vpix) ? pixels : border;
    blk1_d  = hblank || vblank;
    addr1_d = {bank_cur_q, idx1};
  end

  // blk1 resets to "blanked" so the first clock after reset never exposes an
  // unwritten palette entry on color.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr1_q <= '0;
      blk1_q  <= 1'b1;
    end else begin
      addr1_q <= addr1_d;
      blk1_q  <= blk1_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: palette lookup and blanking.
  // ---------------------------------------------------------------------------
  logic [COL_W-1:0] color_q;
  logic             blank_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      color_q <= '0;
      blank_q <= 1'b1;
    end else begin
      color_q <= blk1_q ? '0 : pal_q[addr1_q];
      blank_q <= blk1_q;
    end
  end

  assign color     = color_q;
  assign blank_out = blank_q;

  // ---------------------------------------------------------------------------
  // Readback FSM.
  // The display only reads the RAM when stage 1 holds an unblanked address,
  // so WAIT moves to READ only when blk1 is set. The RAM read and the ack
  // are registered on the WAIT->READ edge. That makes pal_rd_ack high for
  // exactly the cycle spent in READ, with pal_rd_data valid alongside it.
  // ---------------------------------------------------------------------------
  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [COL_W-1:0]  rd_data_q;
  logic              rd_ack_q;
  logic              load_rd;

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    load_rd   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pal_bus.pal_rd_req) begin
          rd_addr_d = pal_bus.pal_rd_addr;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!pal_bus.pal_rd_req) begin
          state_d = S_IDLE;
        end else if (blk1_q) begin
          state_d = S_READ;
          load_rd = 1'b1;
        end
      end
      S_READ: begin
        state_d = S_ACK;
      end
      S_ACK: begin
        if (!pal_bus.pal_rd_req) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      rd_ack_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      rd_ack_q  <= load_rd;
      if (load_rd) begin
        rd_data_q <= pal_q[rd_addr_q];
      end
    end
  end

  assign pal_bus.pal_rd_ack  = rd_ack_q;
  assign pal_bus.pal_rd_data = rd_data_q;
  assign dbg_rd_state        = state_q;

endmodule

// File: tb/tb_video_palframe_gen.sv
module tb_video_palframe_gen;

  localparam int IDX_W  = 4;
  localparam int COL_W  = 6;
  localparam int BANK_W = 1;
  localparam int ADDR_W = BANK_W + IDX_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd3;

  // ---------------------------------------------------------------- clock/reset
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic              hpix, vpix, hblank, vblank;
  logic [IDX_W-1:0]  pixels, border;
  logic [BANK_W-1:0] bank_sel;
  logic [COL_W-1:0]  color;
  logic              blank_out;
  logic [1:0]        dbg_rd_state;

  video_palframe_gen_if #(.IDX_W(IDX_W), .COL_W(COL_W), .BANK_W(BANK_W)) bus ();

  video_palframe_gen #(.IDX_W(IDX_W), .COL_W(COL_W), .BANK_W(BANK_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hpix         (hpix),
    .vpix         (vpix),
    .hblank       (hblank),
    .vblank       (vblank),
    .pixels       (pixels),
    .border       (border),
    .bank_sel     (bank_sel),
    .pal_bus      (bus),
    .color        (color),
    .blank_out    (blank_out),
    .dbg_rd_state (dbg_rd_state)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // ---------------------------------------------------------------- drivers
  // Inputs change and outputs are sampled 1 time unit after a rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_pal(input logic [ADDR_W-1:0] a, input logic [COL_W-1:0] d);
    bus.pal_we    = 1'b1;
    bus.pal_waddr = a;
    bus.pal_wdata = d;
    step(1);
    bus.pal_we    = 1'b0;
  endtask

  task automatic set_active(input logic [IDX_W-1:0] px);
    hpix = 1'b1; vpix = 1'b1; hblank = 1'b0; vblank = 1'b0; pixels = px;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset;
    rst_n = 1'b0;
    hpix = 0; vpix = 0; hblank = 1; vblank = 1;
    pixels = '0; border = '0; bank_sel = '0;
    bus.pal_we = 0; bus.pal_waddr = '0; bus.pal_wdata = '0;
    bus.pal_rd_req = 0; bus.pal_rd_addr = '0;
    step(3);
    total_cnt++;
    if (color !== 6'h00) $display("FAIL reset_color got %0h exp 0", color); else pass_cnt++;
    total_cnt++;
    if (blank_out !== 1'b1) $display("FAIL reset_blank got %0b exp 1", blank_out); else pass_cnt++;
    total_cnt++;
    if (bus.pal_rd_ack !== 1'b0) $display("FAIL reset_ack got %0b exp 0", bus.pal_rd_ack); else pass_cnt++;
    total_cnt++;
    if (bus.pal_rd_data !== 6'h00) $display("FAIL reset_rd_data got %0h exp 0", bus.pal_rd_data); else pass_cnt++;
    total_cnt++;
    if (dbg_rd_state !== ST_IDLE) $display("FAIL reset_state got %0d exp 0", dbg_rd_state); else pass_cnt++;
    rst_n = 1'b1;
    step(2);
    total_cnt++;
    if (color !== 6'h00 || blank_out !== 1'b1)
      $display("FAIL post_reset_blank got color=%0h blank=%0b exp 0/1", color, blank_out);
    else pass_cnt++;
  endtask

  task automatic test_pixel;
    write_pal(5'h03, 6'h2A);
    set_active(4'd3);
    step(1);
    total_cnt++;
    if (color !== 6'h00 || blank_out !== 1'b1)
      $display("FAIL pixel_lat1 got color=%0h blank=%0b exp 0/1", color, blank_out);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (color !== 6'h2A || blank_out !== 1'b0)
      $display("FAIL pixel_lat2 got color=%0h blank=%0b exp 2a/0", color, blank_out);
    else pass_cnt++;
  endtask

  task automatic test_border_blank;
    write_pal(5'h05, 6'h15);
    hpix = 1'b0; border = 4'd5;
    step(2);
    total_cnt++;
    if (color !== 6'h15) $display("FAIL border_color got %0h exp 15", color); else pass_cnt++;
    hblank = 1'b1;
    step(1);
    total_cnt++;
    if (color !== 6'h15 || blank_out !== 1'b0)
      $display("FAIL hblank_lat1 got color=%0h blank=%0b exp 15/0", color, blank_out);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (color !== 6'h00 || blank_out !== 1'b1)
      $display("FAIL hblank_lat2 got color=%0h blank=%0b exp 0/1", color, blank_out);
    else pass_cnt++;
  endtask

  task automatic test_bank_switch;
    write_pal(5'h13, 6'h3F);
    set_active(4'd3);
    bank_sel = 1'b1;
    step(2);
    total_cnt++;
    if (color !== 6'h2A) $display("FAIL bank_hold0 got %0h exp 2a", color); else pass_cnt++;
    step(5);
    total_cnt++;
    if (color !== 6'h2A) $display("FAIL bank_hold1 got %0h exp 2a", color); else pass_cnt++;
    vblank = 1'b1;
    step(1);
    vblank = 1'b0;
    step(1);
    total_cnt++;
    if (color !== 6'h00 || blank_out !== 1'b1)
      $display("FAIL bank_vblank got color=%0h blank=%0b exp 0/1", color, blank_out);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (color !== 6'h3F) $display("FAIL bank_switched got %0h exp 3f", color); else pass_cnt++;
  endtask

  task automatic test_readback;
    int acks;
    int first_ack;
    logic [COL_W-1:0] got;
    acks = 0; first_ack = -1; got = '0;
    bus.pal_rd_addr = 5'h13;
    bus.pal_rd_req  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (bus.pal_rd_ack === 1'b1) acks++;
    end
    total_cnt++;
    if (acks !== 0) $display("FAIL rb_active_noack got %0d acks exp 0", acks); else pass_cnt++;
    total_cnt++;
    if (dbg_rd_state !== ST_WAIT) $display("FAIL rb_wait_state got %0d exp 1", dbg_rd_state); else pass_cnt++;
    hblank = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      if (bus.pal_rd_ack === 1'b1) begin
        acks++;
        if (first_ack < 0) begin
          first_ack = i;
          got = bus.pal_rd_data;
        end
      end
    end
    total_cnt++;
    if (acks !== 1) $display("FAIL rb_one_ack got %0d acks exp 1", acks); else pass_cnt++;
    total_cnt++;
    if (first_ack !== 2) $display("FAIL rb_ack_latency got %0d exp 2", first_ack); else pass_cnt++;
    total_cnt++;
    if (got !== 6'h3F) $display("FAIL rb_data got %0h exp 3f", got); else pass_cnt++;
    total_cnt++;
    if (dbg_rd_state !== ST_ACK || bus.pal_rd_data !== 6'h3F)
      $display("FAIL rb_held got state=%0d data=%0h exp 3/3f", dbg_rd_state, bus.pal_rd_data);
    else pass_cnt++;
    bus.pal_rd_req = 1'b0;
    step(1);
    total_cnt++;
    if (dbg_rd_state !== ST_IDLE) $display("FAIL rb_release got %0d exp 0", dbg_rd_state); else pass_cnt++;
    hblank = 1'b0;
    step(2);
  endtask

  task automatic test_abort;
    int acks;
    logic got_ack;
    logic [COL_W-1:0] got;
    acks = 0; got_ack = 1'b0; got = '0;
    bus.pal_rd_addr = 5'h05;
    bus.pal_rd_req  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      if (bus.pal_rd_ack === 1'b1) acks++;
    end
    bus.pal_rd_req = 1'b0;
    step(1);
    if (bus.pal_rd_ack === 1'b1) acks++;
    total_cnt++;
    if (acks !== 0 || dbg_rd_state !== ST_IDLE)
      $display("FAIL abort got acks=%0d state=%0d exp 0/0", acks, dbg_rd_state);
    else pass_cnt++;
    // A fresh request during blanking is served normally.
    hblank = 1'b1;
    bus.pal_rd_addr = 5'h03;
    bus.pal_rd_req  = 1'b1;
    for (int i = 0; i < 10 && !got_ack; i++) begin
      step(1);
      if (bus.pal_rd_ack === 1'b1) begin
        got_ack = 1'b1;
        got = bus.pal_rd_data;
      end
    end
    total_cnt++;
    if (!got_ack || got !== 6'h2A)
      $display("FAIL abort_new_req got ack=%0b data=%0h exp 1/2a", got_ack, got);
    else pass_cnt++;
    bus.pal_rd_req = 1'b0;
    hblank = 1'b0;
    step(1);
  endtask

  task automatic test_collision;
    bank_sel = 1'b0;
    vblank = 1'b1;
    step(1);
    set_active(4'd3);
    step(1);
    bus.pal_we    = 1'b1;
    bus.pal_waddr = 5'h03;
    bus.pal_wdata = 6'h11;
    step(1);
    bus.pal_we = 1'b0;
    total_cnt++;
    if (color !== 6'h2A) $display("FAIL collide_old got %0h exp 2a", color); else pass_cnt++;
    step(1);
    total_cnt++;
    if (color !== 6'h11) $display("FAIL collide_new got %0h exp 11", color); else pass_cnt++;
  endtask

  task automatic test_async_reset;
    bus.pal_rd_addr = 5'h03;
    bus.pal_rd_req  = 1'b1;
    step(2);
    total_cnt++;
    if (dbg_rd_state !== ST_WAIT || color !== 6'h11)
      $display("FAIL pre_reset got state=%0d color=%0h exp 1/11", dbg_rd_state, color);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (color !== 6'h00 || blank_out !== 1'b1)
      $display("FAIL async_rst_video got color=%0h blank=%0b exp 0/1", color, blank_out);
    else pass_cnt++;
    total_cnt++;
    if (dbg_rd_state !== ST_IDLE || bus.pal_rd_ack !== 1'b0)
      $display("FAIL async_rst_fsm got state=%0d ack=%0b exp 0/0", dbg_rd_state, bus.pal_rd_ack);
    else pass_cnt++;
    bus.pal_rd_req = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(1);
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    test_reset();
    test_pixel();
    test_border_blank();
    test_bank_switch();
    test_readback();
    test_abort();
    test_collision();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
